// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - signed multiply/divide sequencer driving a shared add/subtract unit
// Radix-2 Booth multiply and restoring magnitude divide, one adder pass per clock.
module multdiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_ABS_A,
    S_ABS_B,
    S_DIV,
    S_FIX
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);
  localparam logic [5:0] MULT_DONE = 6'(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic             r_q, w_q_nxt;
  logic             r_neg, w_neg_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_exc, w_exc_nxt;
  logic             r_rdy, w_rdy_nxt;

  logic             w_start;
  logic             w_s33;
  logic             w_cout;
  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH-1:0] w_quo_sh;

  assign w_start  = ctrl_MULT | ctrl_DIV;
  assign w_rem_sh = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_quo_sh = {r_lo[WIDTH-2:0], 1'b0};

  // Sign of the 33-bit sum and unsigned carry-out, recovered from the driven adder bits.
  assign w_s33  = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                  ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & add_sum[WIDTH-1]);
  assign w_cout = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                  ((add_a[WIDTH-1] | add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_q      <= 1'b0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_q      <= w_q_nxt;
      r_neg    <= w_neg_nxt;
      r_result <= w_result_nxt;
      r_exc    <= w_exc_nxt;
      r_rdy    <= w_rdy_nxt;
    end
  end

  // Adder operand selection, kept apart from next-state so the adder feedback is not a loop.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (r_state)
      S_MULT: begin
        if (r_cnt != MULT_DONE) begin
          add_a = r_hi;
          case ({r_lo[0], r_q})
            2'b01: add_b = r_b;
            2'b10: begin
              add_b   = ~r_b;
              add_cin = 1'b1;
            end
            default: add_b = '0;
          endcase
        end
      end
      S_ABS_A: begin
        add_a   = r_a[WIDTH-1] ? ~r_a : r_a;
        add_cin = r_a[WIDTH-1];
      end
      S_ABS_B: begin
        add_a   = r_b[WIDTH-1] ? ~r_b : r_b;
        add_cin = r_b[WIDTH-1];
      end
      S_DIV: begin
        add_a   = w_rem_sh;
        add_b   = ~r_b;
        add_cin = 1'b1;
      end
      S_FIX: begin
        add_a   = r_neg ? ~r_lo : r_lo;
        add_cin = r_neg;
      end
      default: begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_q_nxt      = r_q;
    w_neg_nxt    = r_neg;
    w_result_nxt = r_result;
    w_exc_nxt    = r_exc;
    w_rdy_nxt    = 1'b0;

    case (r_state)
      S_MULT: begin
        if (r_cnt == MULT_DONE) begin
          w_result_nxt = r_lo;
          w_exc_nxt    = (r_hi != {WIDTH{r_lo[WIDTH-1]}});
          w_rdy_nxt    = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_hi_nxt  = {w_s33, add_sum[WIDTH-1:1]};
          w_lo_nxt  = {add_sum[0], r_lo[WIDTH-1:1]};
          w_q_nxt   = r_lo[0];
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      S_ABS_A: begin
        w_hi_nxt    = '0;
        w_lo_nxt    = add_sum;
        w_neg_nxt   = r_a[WIDTH-1] ^ r_b[WIDTH-1];
        w_state_nxt = S_ABS_B;
      end
      S_ABS_B: begin
        w_b_nxt     = add_sum;
        w_cnt_nxt   = '0;
        w_state_nxt = S_DIV;
      end
      S_DIV: begin
        if (w_cout) begin
          w_hi_nxt = add_sum;
          w_lo_nxt = w_quo_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          w_hi_nxt = w_rem_sh;
          w_lo_nxt = w_quo_sh;
        end
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == LAST_STEP) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        // r_b holds |B| here; it is zero exactly when the divisor was zero.
        w_result_nxt = (r_b == '0) ? '0 : add_sum;
        w_exc_nxt    = (r_b == '0);
        w_rdy_nxt    = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A new start aborts whatever is running; a finishing op still reports its own exception.
    if (w_start) begin
      if (!w_rdy_nxt) begin
        w_exc_nxt = 1'b0;
      end
      w_a_nxt     = data_operandA;
      w_b_nxt     = data_operandB;
      w_hi_nxt    = '0;
      w_lo_nxt    = data_operandA;
      w_q_nxt     = 1'b0;
      w_cnt_nxt   = '0;
      w_state_nxt = ctrl_MULT ? S_MULT : S_ABS_A;
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - self-checking bench for multdiv_ctrl against an arithmetic model
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_ctrl #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .add_a          (add_a),
    .add_b          (add_b),
    .add_cin        (add_cin),
    .add_sum        (add_sum),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  assign add_sum = add_a + add_b + {31'b0, add_cin};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [32:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic   ovf;
    logic [63:0] pv;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p   = sa * sb;
    ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    pv  = p;
    return {ovf, pv[31:0]};
  endfunction

  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    logic [63:0] qv;
    if (b == 32'h0) return {1'b1, 32'h0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    qv = q;
    return {1'b0, qv[31:0]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and wait (bounded) for RDY; lat stays -1 if it never arrives.
  task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic exc);
    lat = -1;
    res = 'x;
    exc = 1'bx;
    @(negedge clock);
    ctrl_MULT     = is_mult;
    ctrl_DIV      = !is_mult;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        res = data_result;
        exc = data_exception;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({busy, data_resultRDY, data_exception, data_result, add_a, add_b, add_cin} !== '0)
      $display("FAIL reset_outputs: got busy=%b rdy=%b exc=%b res=%h a=%h b=%h cin=%b, want all 0",
               busy, data_resultRDY, data_exception, data_result, add_a, add_b, add_cin);
    else n_pass++;
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || add_a !== 32'h0 || add_b !== 32'h0 || add_cin !== 1'b0)
      $display("FAIL idle_adder: got busy=%b a=%h b=%h cin=%b, want 0", busy, add_a, add_b, add_cin);
    else n_pass++;
  endtask

  task automatic test_mult;
    int lat; logic [31:0] res; logic exc;
    run_op(1'b1, 32'd7, 32'hFFFF_FFFD, lat, res, exc);
    n_checks++;
    if (lat !== 33 || res !== 32'hFFFF_FFEB || exc !== 1'b0)
      $display("FAIL mult_7x-3: got lat=%0d res=%h exc=%b, want lat=33 res=ffffffeb exc=0", lat, res, exc);
    else n_pass++;
    @(posedge clock);
    #1;
    n_checks++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b0)
      $display("FAIL rdy_pulse: got rdy=%b busy=%b one cycle after RDY, want 0/0", data_resultRDY, busy);
    else n_pass++;
    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, lat, res, exc);
    n_checks++;
    if (lat !== 33 || res !== 32'h0 || exc !== 1'b1)
      $display("FAIL mult_ovf: got lat=%0d res=%h exc=%b, want lat=33 res=00000000 exc=1", lat, res, exc);
    else n_pass++;
    run_op(1'b1, 32'h8000_0000, 32'h1, lat, res, exc);
    n_checks++;
    if (lat !== 33 || res !== 32'h8000_0000 || exc !== 1'b0)
      $display("FAIL mult_min_x1: got lat=%0d res=%h exc=%b, want lat=33 res=80000000 exc=0", lat, res, exc);
    else n_pass++;
  endtask

  task automatic test_div;
    int lat; logic [31:0] res; logic exc;
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, lat, res, exc);
    n_checks++;
    if (lat !== 35 || res !== 32'hFFFF_FFFD || exc !== 1'b0)
      $display("FAIL div_-7/2: got lat=%0d res=%h exc=%b, want lat=35 res=fffffffd exc=0", lat, res, exc);
    else n_pass++;
    run_op(1'b0, 32'h8000_0000, 32'd1, lat, res, exc);
    n_checks++;
    if (lat !== 35 || res !== 32'h8000_0000 || exc !== 1'b0)
      $display("FAIL div_min/1: got lat=%0d res=%h exc=%b, want lat=35 res=80000000 exc=0", lat, res, exc);
    else n_pass++;
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, exc);
    n_checks++;
    if (lat !== 35 || res !== 32'h8000_0000 || exc !== 1'b0)
      $display("FAIL div_min/-1: got lat=%0d res=%h exc=%b, want lat=35 res=80000000 exc=0", lat, res, exc);
    else n_pass++;
  endtask

  task automatic test_div_zero;
    int lat; logic [31:0] res; logic exc;
    run_op(1'b0, 32'd5, 32'd0, lat, res, exc);
    n_checks++;
    if (lat !== 35 || res !== 32'h0 || exc !== 1'b1)
      $display("FAIL div_by_zero: got lat=%0d res=%h exc=%b, want lat=35 res=00000000 exc=1", lat, res, exc);
    else n_pass++;
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    n_checks++;
    if (data_exception !== 1'b0 || busy !== 1'b1)
      $display("FAIL exc_clear_on_start: got exc=%b busy=%b, want exc=0 busy=1", data_exception, busy);
    else n_pass++;
    repeat (40) @(posedge clock);
  endtask

  task automatic test_abort;
    int rdy_count, rdy_at;
    logic [31:0] res;
    rdy_count = 0;
    rdy_at    = -1;
    res       = '0;
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'h0000_1234;
    data_operandB = 32'h0000_0055;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        rdy_count++;
        rdy_at = i;
        res    = data_result;
      end
      if (i == 9) begin
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
      end
      if (i == 10) ctrl_DIV = 1'b0;
    end
    n_checks++;
    if (rdy_count !== 1 || rdy_at !== 45)
      $display("FAIL abort_rdy: got %0d pulses last at %0d, want 1 pulse at 45", rdy_count, rdy_at);
    else n_pass++;
    n_checks++;
    if (res !== 32'd14)
      $display("FAIL abort_result: got %h, want 0000000e", res);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int rdy_count;
    int at0, at1;
    logic [31:0] res0, res1;
    logic exc0, exc1;
    rdy_count = 0;
    at0 = -1; at1 = -1;
    res0 = 'x; res1 = 'x; exc0 = 1'bx; exc1 = 1'bx;
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'h0001_0000;
    data_operandB = 32'h0001_0000;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        if (rdy_count == 0) begin at0 = i; res0 = data_result; exc0 = data_exception; end
        else begin at1 = i; res1 = data_result; exc1 = data_exception; end
        rdy_count++;
      end
      if (i == 32) begin
        ctrl_DIV      = 1'b1;
        data_operandA = 32'hFFFF_FF9C;
        data_operandB = 32'd9;
      end
      if (i == 33) ctrl_DIV = 1'b0;
    end
    n_checks++;
    if (rdy_count !== 2 || at0 !== 33 || at1 !== 68)
      $display("FAIL b2b_timing: got %0d pulses at %0d,%0d, want 2 at 33,68", rdy_count, at0, at1);
    else n_pass++;
    n_checks++;
    if (res0 !== 32'h0 || exc0 !== 1'b1)
      $display("FAIL b2b_first: got res=%h exc=%b, want 00000000/1", res0, exc0);
    else n_pass++;
    n_checks++;
    if (res1 !== 32'hFFFF_FFF5 || exc1 !== 1'b0)
      $display("FAIL b2b_second: got res=%h exc=%b, want fffffff5/0", res1, exc1);
    else n_pass++;
  endtask

  task automatic test_random;
    int lat; logic [31:0] res; logic exc;
    logic [31:0] a, b;
    logic [32:0] exp_v;
    bit is_mult;
    for (int k = 0; k < 24; k++) begin
      a       = pick_operand();
      b       = pick_operand();
      is_mult = 1'($urandom_range(0, 1));
      exp_v   = is_mult ? ref_mult(a, b) : ref_div(a, b);
      run_op(is_mult, a, b, lat, res, exc);
      n_checks++;
      if (lat !== (is_mult ? 33 : 35) || res !== exp_v[31:0] || exc !== exp_v[32])
        $display("FAIL rand_%s a=%h b=%h: got lat=%0d res=%h exc=%b, want lat=%0d res=%h exc=%b",
                 is_mult ? "mult" : "div", a, b, lat, res, exc, is_mult ? 33 : 35,
                 exp_v[31:0], exp_v[32]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midop;
    int lat; logic [31:0] res; logic exc;
    int rdy_count;
    run_op(1'b1, 32'd6, 32'd7, lat, res, exc);
    n_checks++;
    if (res !== 32'd42 || lat !== 33)
      $display("FAIL pre_reset_mult: got lat=%0d res=%h, want 33/0000002a", lat, res);
    else n_pass++;
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'hFFFF_FFFB;
    data_operandB = 32'd77;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b1)
      $display("FAIL busy_midop: got %b, want 1", busy);
    else n_pass++;
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if ({busy, data_resultRDY, data_exception, data_result, add_a, add_b, add_cin} !== '0)
      $display("FAIL midop_reset: got busy=%b rdy=%b exc=%b res=%h a=%h b=%h cin=%b, want all 0",
               busy, data_resultRDY, data_exception, data_result, add_a, add_b, add_cin);
    else n_pass++;
    reset     = 1'b1;
    rdy_count = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_count++;
    end
    n_checks++;
    if (rdy_count !== 0)
      $display("FAIL no_rdy_after_reset: got %0d pulses, want 0", rdy_count);
    else n_pass++;
  endtask

  initial begin
    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
